// File: rtl/mem_reg_mp.sv
// mem_reg_mp: multi-port register file with p_READ_PORTS asynchronous read
// ports, two prioritised synchronous write ports (port 1 wins on collision)
// and a clear sequencer that zeroes entries 1..p_REG_FILE_SIZE-1, one per
// cycle, after reset or on i_clear. Register 0 always reads as zero.
// Optional feature macro: REG_BYPASS_EN. When it is defined, reads forward
// same-cycle write data.
module mem_reg_mp #(
  parameter int p_WORD_LEN      = 16,
  parameter int p_REG_ADDR_LEN  = 3,
  parameter int p_REG_FILE_SIZE = 8,
  parameter int p_READ_PORTS    = 2
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_clear,
  output logic                                   o_ready,
  input  logic [p_READ_PORTS*p_REG_ADDR_LEN-1:0] i_src,
  output logic [p_READ_PORTS*p_WORD_LEN-1:0]     o_src_data,
  input  logic [1:0]                             i_wr_en,
  input  logic [2*p_REG_ADDR_LEN-1:0]            i_tgt,
  input  logic [2*p_WORD_LEN-1:0]                i_tgt_data
);

  localparam int W = p_WORD_LEN;
  localparam int A = p_REG_ADDR_LEN;

  // The last entry the sequencer clears; the edge that clears it ends CLEAR.
  localparam logic [A-1:0] LAST_PTR  = A'(p_REG_FILE_SIZE - 1);
  localparam logic [A-1:0] FIRST_PTR = A'(1);
  // One bit wider than an address so a full 2^A file still compares correctly.
  localparam logic [A:0]   SIZE_LIM  = (A + 1)'(p_REG_FILE_SIZE);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Zero-initialised so reads are defined even before the first reset.
  state_t         state_r = ST_CLEAR;
  logic [A-1:0]   ptr_r   = FIRST_PTR;
  logic           ready_r = 1'b0;
  logic [W-1:0]   mem_r [p_REG_FILE_SIZE] = '{default: '0};

  logic           clr_we_s;
  logic           wr_open_s;
  logic [1:0]     w_ok_s;
  logic [p_READ_PORTS*W-1:0] rd_s;

  // An address names real storage: not r0 and inside the file.
  function automatic logic addr_live(input logic [A-1:0] addr);
    return (addr != {A{1'b0}}) && ({1'b0, addr} < SIZE_LIM);
  endfunction

  assign o_ready    = ready_r;
  assign o_src_data = rd_s;

  // Decide which storage writes land on this edge (clear step or user ports).
  always_comb begin
    clr_we_s  = 1'b0;
    wr_open_s = 1'b0;
    w_ok_s    = 2'b00;
    if (i_rst_n && (state_r == ST_CLEAR)) begin
      clr_we_s = 1'b1;
    end else begin
      clr_we_s = 1'b0;
    end
    // A clear request on the same edge wins over user writes.
    if (i_rst_n && (state_r == ST_IDLE) && !i_clear) begin
      wr_open_s = 1'b1;
    end else begin
      wr_open_s = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      w_ok_s[k] = wr_open_s && i_wr_en[k] && addr_live(i_tgt[k*A +: A]);
    end
  end

  // Sequencer: reset/clear restart at entry 1, IDLE once the last entry is cleared.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_CLEAR;
      ptr_r   <= FIRST_PTR;
      ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (ptr_r == LAST_PTR) begin
            state_r <= ST_IDLE;
            ptr_r   <= FIRST_PTR;
            ready_r <= 1'b1;
          end else begin
            ptr_r   <= ptr_r + FIRST_PTR;
          end
        end
        ST_IDLE: begin
          if (i_clear) begin
            state_r <= ST_CLEAR;
            ptr_r   <= FIRST_PTR;
            ready_r <= 1'b0;
          end else begin
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_CLEAR;
          ptr_r   <= FIRST_PTR;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Storage update; port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge i_clk) begin
    if (clr_we_s) begin
      mem_r[ptr_r] <= {W{1'b0}};
    end else begin
      if (w_ok_s[0]) begin
        mem_r[i_tgt[0*A +: A]] <= i_tgt_data[0*W +: W];
      end
      if (w_ok_s[1]) begin
        mem_r[i_tgt[1*A +: A]] <= i_tgt_data[1*W +: W];
      end
    end
  end

  // Combinational read ports: zero for r0, out-of-range or not ready.
  always_comb begin
    rd_s = '0;
    for (int k = 0; k < p_READ_PORTS; k++) begin
      if (ready_r && addr_live(i_src[k*A +: A])) begin
        rd_s[k*W +: W] = mem_r[i_src[k*A +: A]];
`ifdef REG_BYPASS_EN
        // Forward in-flight writes; port 1 checked last so it has priority.
        for (int j = 0; j < 2; j++) begin
          if (w_ok_s[j] && (i_tgt[j*A +: A] == i_src[k*A +: A])) begin
            rd_s[k*W +: W] = i_tgt_data[j*W +: W];
          end else begin
            rd_s[k*W +: W] = rd_s[k*W +: W];
          end
        end
`endif
      end else begin
        rd_s[k*W +: W] = {W{1'b0}};
      end
    end
  end

endmodule

// File: doc/mem_reg_mp.md
# mem_reg_mp

Multi-port, parametrised successor to the core's register file: `p_READ_PORTS` asynchronous read ports, two prioritised synchronous write ports, and a hardware clear sequencer that zeroes the file one entry per cycle after reset or on request. It sits in the pipelined core's decode/writeback stages. Register 0 is hard-wired to zero, and `o_ready` tells the pipeline when the file holds valid state.

## Interface
- `p_WORD_LEN`, 16, data width of each register.
- `p_REG_ADDR_LEN`, 3, register address width.
- `p_REG_FILE_SIZE`, 8, number of registers including r0; must be ≤ 2^`p_REG_ADDR_LEN` and ≥ 2.
- `p_READ_PORTS`, 2, number of read ports; must be ≥ 1.

- `i_clk`, in, 1, clock; all state changes on posedge.
- `i_rst_n`, in, 1, reset; synchronous, active-low.
- `i_clear`, in, 1, request a full clear; sampled on posedge.
- `o_ready`, out, 1, high when the file is valid and accepting writes.
- `i_src`, in, `p_READ_PORTS*p_REG_ADDR_LEN`, read addresses; port k uses `[k*p_REG_ADDR_LEN +: p_REG_ADDR_LEN]`.
- `o_src_data`, out, `p_READ_PORTS*p_WORD_LEN`, read data, asynchronous; port k uses `[k*p_WORD_LEN +: p_WORD_LEN]`.
- `i_wr_en`, in, 2, per-write-port enable.
- `i_tgt`, in, `2*p_REG_ADDR_LEN`, write addresses; port k uses `[k*p_REG_ADDR_LEN +: p_REG_ADDR_LEN]`.
- `i_tgt_data`, in, `2*p_WORD_LEN`, write data, packed the same way.

## Operation
- **States:** CLEAR and IDLE. `o_ready` = (state == IDLE).
- **Reset:** any posedge with `i_rst_n` low sets state to CLEAR, clear pointer to 1, and `o_ready` to 0. Storage is not touched on that edge.
- **CLEAR:** each posedge with `i_rst_n` high writes 0 to `mem[ptr]` and increments `ptr`.
  - On the edge that clears `p_REG_FILE_SIZE-1`, state goes to IDLE.
  - All writes and `i_clear` are ignored while in CLEAR.
- **IDLE:** `i_clear` high on a posedge enters CLEAR with `ptr` = 1. Writes presented on that same edge are dropped; clear wins.
- **Writes (IDLE only):** port k writes `i_tgt_data[k]` to `mem[i_tgt[k]]` when `i_wr_en[k]` is high and `i_tgt[k]` ≠ 0.
  - If both ports target the same nonzero address, port 1's data is stored.
  - A write to address 0 is discarded.
- **Reads:**
  - Address 0 returns 0.
  - Any address ≥ `p_REG_FILE_SIZE` returns 0.
  - While `o_ready` is low, every read port returns 0.
  - Otherwise a read returns `mem[addr]`, subject to forwarding (see Configuration).
  - Outputs are never X, including before the first reset, because storage is zero-initialised in simulation.

## Timing
- **Reset to ready:** after `i_rst_n` rises, `o_ready` goes high after exactly `p_REG_FILE_SIZE-1` posedges (7 at default).
- **Clear request:** `i_clear` in IDLE drops `o_ready` on the next posedge. Ready returns `p_REG_FILE_SIZE-1` edges later.
- **Reset during CLEAR:** restarts the sequence with `ptr` = 1.
- **Write latency:** the stored value is visible to reads in the cycle after the write edge, with zero latency when forwarding is compiled in.
- **Read path:** purely combinational from `i_src`, `mem`, and, when forwarding is enabled, the write ports.

## Configuration
- **`REG_BYPASS_EN` defined:** a read port whose address matches an enabled, nonzero write target returns that write data combinationally in the same cycle.
  - Port 1 has priority over port 0.
  - Forwarding only occurs when `o_ready` is high and `i_clear` is low.
- **`REG_BYPASS_EN` undefined:** reads always return stored contents; the new value appears the cycle after the write edge.

## Test plan
- **Reset and clear sequence:** preload r3 = 16'hBEEF, then hold `i_rst_n` low for 2 cycles and release -> `o_ready` is 0 for 7 edges, then 1; r3 reads 16'h0000; all ports read 0 while not ready.
- **Basic write and r0:** in IDLE, write port 0 r5 = 16'h1234 and port 1 r0 = 16'hFFFF -> next cycle r5 reads 16'h1234 on every read port; r0 reads 16'h0000.
- **Write collision:** both ports write r2 in the same cycle, port 0 = 16'hAAAA and port 1 = 16'h5555 -> r2 reads 16'h5555.
- **Forwarding:** read r4 while writing r4 = 16'hC0DE in the same cycle -> with `REG_BYPASS_EN`, read returns 16'hC0DE in that cycle; without it, read returns the old value (16'h0000) and 16'hC0DE the next cycle.
- **Clear versus write:** pulse `i_clear` together with a write r6 = 16'h0F0F, and write r1 during CLEAR -> both writes are lost; after ready, r6 and r1 read 0.
- **Reset mid-clear:** assert `i_rst_n` low at clear step 3 -> the sequence restarts and `o_ready` rises 7 edges after release.
